// File: rtl/keypad_scanner_if.sv
// Key-event channel between the keypad scanner and its consumer.
//
// Signals:
//   key_valid  scanner -> consumer  a key event is being offered
//   key_ready  consumer -> scanner  consumer accepts the offered event
//   key_row    scanner -> consumer  row index of the key
//   key_col    scanner -> consumer  column index of the key
//
// Modports: master (scanner side), slave (consumer side).
`timescale 1ns/1ps

interface keypad_scanner_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic          key_valid;
    logic          key_ready;
    logic [RW-1:0] key_row;
    logic [CW-1:0] key_col;

    modport master (
        output key_valid,
        output key_row,
        output key_col,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_row,
        input  key_col,
        output key_ready
    );
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner with debounce and a valid/ready key-event output.
//
// Columns are driven active-low one at a time; each column is held for
// SCAN_DIV clocks and the synchronized row lines are sampled on the last
// clock of that dwell. A single active row must be seen on DEBOUNCE
// consecutive samples before a key event is emitted, and DEBOUNCE
// consecutive empty samples are needed before scanning moves on.
//
// Ports:
//   clk        rising-edge clock
//   nRst       asynchronous active-low reset
//   enable     scan enable; low forces the idle state
//   read_row   raw row lines, active-high, asynchronous to clk
//   scan_col   column drive, active-low, one-cold while scanning
//   key_if     key event channel (master): key_valid/key_ready/key_row/key_col
//   multi_err  one-cycle pulse: more than one row active in a sample
//   overflow   one-cycle pulse: qualified key dropped (previous not taken)
`timescale 1ns/1ps

module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              enable,
    input  logic [ROWS-1:0]   read_row,
    output logic [COLS-1:0]   scan_col,
    keypad_scanner_if.master  key_if,
    output logic              multi_err,
    output logic              overflow
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW = $clog2(SCAN_DIV);
    localparam int NW = $clog2(DEBOUNCE + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [NW-1:0] CNT_DONE   = NW'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD
    } state_t;

    state_t          state, state_n;
    logic [ROWS-1:0] row_meta, row_sync;
    logic [DW-1:0]   dwell, dwell_n;
    logic [CW-1:0]   col, col_n, col_adv;
    logic [NW-1:0]   cnt, cnt_n, cnt_inc;
    logic [RW-1:0]   cap_row, cap_row_n;
    logic [RW-1:0]   row_idx;
    logic [COLS-1:0] scan_col_n;
    logic            rows_zero, rows_one;
    logic            sample;
    logic            emit;
    logic            multi_n;

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            row_meta <= '0;
            row_sync <= '0;
        end else begin
            row_meta <= read_row;
            row_sync <= row_meta;
        end
    end

    // Classify the synchronized rows: none, exactly one (with its index), or several.
    always_comb begin
        rows_zero = (row_sync == '0);
        rows_one  = !rows_zero && ((row_sync & (row_sync - ROWS'(1))) == '0);
        row_idx   = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (row_sync[i]) begin
                row_idx = RW'(i);
            end
        end
    end

    assign sample  = (state != ST_IDLE) && (dwell == DWELL_LAST);
    assign col_adv = (col == COL_LAST) ? '0 : col + CW'(1);
    assign cnt_inc = cnt + NW'(1);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state    <= ST_IDLE;
            dwell    <= '0;
            col      <= '0;
            cnt      <= '0;
            cap_row  <= '0;
            scan_col <= '1;
        end else begin
            state    <= state_n;
            dwell    <= dwell_n;
            col      <= col_n;
            cnt      <= cnt_n;
            cap_row  <= cap_row_n;
            scan_col <= scan_col_n;
        end
    end

    // cnt is the press-match count in ST_DEBOUNCE and the release count in ST_HELD.
    always_comb begin
        state_n   = state;
        dwell_n   = sample ? '0 : dwell + DW'(1);
        col_n     = col;
        cnt_n     = cnt;
        cap_row_n = cap_row;
        emit      = 1'b0;
        multi_n   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                dwell_n = '0;
                col_n   = '0;
                cnt_n   = '0;
                if (enable) begin
                    state_n = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (sample) begin
                    multi_n = !rows_zero && !rows_one;
                    if (rows_one) begin
                        cap_row_n = row_idx;
                        if (DEBOUNCE == 1) begin
                            emit    = 1'b1;
                            state_n = ST_HELD;
                            cnt_n   = '0;
                        end else begin
                            state_n = ST_DEBOUNCE;
                            cnt_n   = NW'(1);
                        end
                    end else begin
                        col_n = col_adv;
                    end
                end
            end

            ST_DEBOUNCE: begin
                if (sample) begin
                    multi_n = !rows_zero && !rows_one;
                    if (rows_one && (row_idx == cap_row)) begin
                        if (cnt_inc == CNT_DONE) begin
                            emit    = 1'b1;
                            state_n = ST_HELD;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = ST_SCAN;
                        col_n   = col_adv;
                        cnt_n   = '0;
                    end
                end
            end

            ST_HELD: begin
                if (sample) begin
                    multi_n = !rows_zero && !rows_one;
                    if (rows_zero) begin
                        if (cnt_inc == CNT_DONE) begin
                            state_n = ST_SCAN;
                            col_n   = col_adv;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        cnt_n = '0;
                    end
                end
            end

            default: state_n = ST_IDLE;
        endcase

        // Disable wins over everything and discards scan/debounce progress.
        if (!enable) begin
            state_n = ST_IDLE;
            dwell_n = '0;
            col_n   = '0;
            cnt_n   = '0;
            emit    = 1'b0;
            multi_n = 1'b0;
        end
    end

    // Column drive is registered from the next column so it only moves at edges.
    always_comb begin
        scan_col_n = '1;
        if (state_n != ST_IDLE) begin
            for (int unsigned i = 0; i < COLS; i++) begin
                if (col_n == CW'(i)) begin
                    scan_col_n[i] = 1'b0;
                end
            end
        end
    end

    // Key event holding register. An emit is accepted when the slot is empty
    // or being drained this cycle; otherwise it is dropped and flagged.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            key_if.key_valid <= 1'b0;
            key_if.key_row   <= '0;
            key_if.key_col   <= '0;
            multi_err        <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            multi_err <= multi_n;
            overflow  <= emit && key_if.key_valid && !key_if.key_ready;
            if (emit && (!key_if.key_valid || key_if.key_ready)) begin
                key_if.key_valid <= 1'b1;
                key_if.key_row   <= cap_row_n;
                key_if.key_col   <= col;
            end else if (key_if.key_ready) begin
                key_if.key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner (ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=2).
// A keypad matrix model turns pressed keys plus the driven column into row lines.
`timescale 1ns/1ps

module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  read_row;
    logic [3:0]  scan_col;
    logic        multi_err;
    logic        overflow;
    logic [15:0] key_map = '0;   // bit r*4+c set = key (row r, col c) pressed

    int checks = 0;
    int errors = 0;
    int valid_rises = 0;
    int multi_cnt = 0;
    int ovf_cnt = 0;
    logic prev_valid = 1'b0;

    keypad_scanner_if #(.ROWS(4), .COLS(4)) kif ();

    keypad_scanner #(
        .ROWS(4),
        .COLS(4),
        .SCAN_DIV(4),
        .DEBOUNCE(2)
    ) dut (
        .clk(clk),
        .nRst(nRst),
        .enable(enable),
        .read_row(read_row),
        .scan_col(scan_col),
        .key_if(kif.master),
        .multi_err(multi_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key connects its row to its column when that column is driven low.
    always_comb begin
        read_row = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_map[r*4 + c] && !scan_col[c]) begin
                    read_row[r] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (kif.key_valid && !prev_valid) valid_rises <= valid_rises + 1;
        prev_valid <= kif.key_valid;
        if (multi_err) multi_cnt <= multi_cnt + 1;
        if (overflow) ovf_cnt <= ovf_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        enable = 1'b0;
        key_map = '0;
        kif.key_ready = 1'b1;
        repeat (2) tick();
        nRst = 1'b1;
        tick();
    endtask

    task automatic wait_for_valid(input int max_cycles);
        int n;
        n = 0;
        while (!kif.key_valid && n < max_cycles) begin
            tick();
            n++;
        end
        check("valid_wait", 32'(kif.key_valid), 32'd1);
    endtask

    task automatic wait_scan(input logic [3:0] target, input int max_cycles);
        int n;
        n = 0;
        while (scan_col != target && n < max_cycles) begin
            tick();
            n++;
        end
        check("scan_wait", 32'(scan_col), 32'(target));
    endtask

    initial begin
        int base_v, base_m, base_o, n;
        kif.key_ready = 1'b1;

        // Reset state.
        tick();
        check("rst_scan_col", 32'(scan_col), 32'hF);
        check("rst_valid", 32'(kif.key_valid), 32'd0);
        check("rst_row", 32'(kif.key_row), 32'd0);
        check("rst_col", 32'(kif.key_col), 32'd0);
        check("rst_multi", 32'(multi_err), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Column rotation with no keys: 4-clock dwell, wrap after column 3.
        do_reset();
        enable = 1'b1;
        tick();
        check("rot_c0", 32'(scan_col), 32'hE);
        repeat (4) tick();
        check("rot_c1", 32'(scan_col), 32'hD);
        repeat (4) tick();
        check("rot_c2", 32'(scan_col), 32'hB);
        repeat (4) tick();
        check("rot_c3", 32'(scan_col), 32'h7);
        repeat (4) tick();
        check("rot_wrap", 32'(scan_col), 32'hE);

        // Single key (2,1) with ready high: one event, column held until release.
        do_reset();
        base_v = valid_rises;
        key_map[2*4 + 1] = 1'b1;
        enable = 1'b1;
        wait_for_valid(60);
        check("k21_row", 32'(kif.key_row), 32'd2);
        check("k21_col", 32'(kif.key_col), 32'd1);
        check("k21_hold", 32'(scan_col), 32'hD);
        tick();
        check("k21_drop", 32'(kif.key_valid), 32'd0);
        repeat (20) tick();
        check("k21_held", 32'(scan_col), 32'hD);
        check("k21_once", 32'(valid_rises - base_v), 32'd1);
        key_map = '0;
        wait_scan(4'hB, 30);

        // Two rows on column 0: multi_err at each column-0 sample, no key.
        do_reset();
        base_v = valid_rises;
        base_m = multi_cnt;
        key_map[0*4 + 0] = 1'b1;
        key_map[3*4 + 0] = 1'b1;
        enable = 1'b1;
        repeat (40) tick();
        check("multi_cnt", 32'(multi_cnt - base_m), 32'd3);
        check("multi_col", 32'(scan_col), 32'hD);
        check("multi_nokey", 32'(valid_rises - base_v), 32'd0);

        // Overflow: ready low, (1,0) pending, then (3,3) qualifies and is dropped.
        do_reset();
        kif.key_ready = 1'b0;
        base_v = valid_rises;
        base_o = ovf_cnt;
        key_map[1*4 + 0] = 1'b1;
        enable = 1'b1;
        wait_for_valid(60);
        check("ovf_row1", 32'(kif.key_row), 32'd1);
        check("ovf_col1", 32'(kif.key_col), 32'd0);
        key_map = '0;
        wait_scan(4'hD, 30);
        key_map[3*4 + 3] = 1'b1;
        n = 0;
        while (ovf_cnt == base_o && n < 80) begin
            tick();
            n++;
        end
        check("ovf_pulse", 32'(ovf_cnt - base_o), 32'd1);
        check("ovf_valid", 32'(kif.key_valid), 32'd1);
        check("ovf_row_kept", 32'(kif.key_row), 32'd1);
        check("ovf_col_kept", 32'(kif.key_col), 32'd0);
        kif.key_ready = 1'b1;
        tick();
        check("ovf_accept", 32'(kif.key_valid), 32'd0);
        repeat (10) tick();
        check("ovf_single", 32'(ovf_cnt - base_o), 32'd1);
        check("ovf_rises", 32'(valid_rises - base_v), 32'd1);

        // One-sample glitch on row 1: enter debounce, then fall back and advance.
        do_reset();
        base_v = valid_rises;
        key_map[1*4 + 0] = 1'b1;
        enable = 1'b1;
        tick();
        check("gl_c0", 32'(scan_col), 32'hE);
        repeat (4) tick();
        check("gl_held", 32'(scan_col), 32'hE);
        key_map = '0;
        repeat (3) tick();
        check("gl_still", 32'(scan_col), 32'hE);
        tick();
        check("gl_adv", 32'(scan_col), 32'hD);
        repeat (30) tick();
        check("gl_nokey", 32'(valid_rises - base_v), 32'd0);

        // Enable dropped during debounce; progress discarded on restart.
        do_reset();
        kif.key_ready = 1'b0;
        key_map[2*4 + 0] = 1'b1;
        enable = 1'b1;
        repeat (5) tick();
        check("en_deb", 32'(scan_col), 32'hE);
        enable = 1'b0;
        tick();
        check("en_idle", 32'(scan_col), 32'hF);
        repeat (3) tick();
        check("en_idle2", 32'(scan_col), 32'hF);
        enable = 1'b1;
        tick();
        check("en_restart", 32'(scan_col), 32'hE);
        repeat (7) tick();
        check("en_not_yet", 32'(kif.key_valid), 32'd0);
        tick();
        check("en_valid", 32'(kif.key_valid), 32'd1);
        check("en_row", 32'(kif.key_row), 32'd2);
        check("en_col", 32'(kif.key_col), 32'd0);

        // Asynchronous reset mid-HELD with a pending key.
        repeat (2) tick();
        nRst = 1'b0;
        #1;
        check("arst_scan", 32'(scan_col), 32'hF);
        check("arst_valid", 32'(kif.key_valid), 32'd0);
        check("arst_row", 32'(kif.key_row), 32'd0);
        check("arst_col", 32'(kif.key_col), 32'd0);
        check("arst_multi", 32'(multi_err), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);

        // Key held through reset release must still be qualified normally.
        tick();
        nRst = 1'b1;
        tick();
        repeat (7) tick();
        check("rr_not_yet", 32'(kif.key_valid), 32'd0);
        tick();
        check("rr_valid", 32'(kif.key_valid), 32'd1);
        check("rr_row", 32'(kif.key_row), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of row inputs (2..8).
REQ-002 SHALL have parameter COLS, default 4, number of driven columns (2..8).
REQ-003 SHALL have parameter SCAN_DIV, default 16, clocks per column dwell (min 3).
REQ-004 SHALL have parameter DEBOUNCE, default 4, consecutive identical samples to qualify a press or release (min 1).
REQ-005 SHALL have port clk  input  1  clock (rising edge).
REQ-006 SHALL have port nRst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port enable  input  1  scan enable.
REQ-008 SHALL have port read_row  input  ROWS  raw row lines, active-high, asynchronous to clk.
REQ-009 SHALL have port scan_col  output  COLS  column drive, active-low, one-cold while scanning, all ones when idle.
REQ-010 SHALL have port key_valid  output  1  key event available.
REQ-011 SHALL have port key_ready  input  1  consumer accepts key event.
REQ-012 SHALL have port key_row  output  clog2(ROWS)  row index of key.
REQ-013 SHALL have port key_col  output  clog2(COLS)  column index of key.
REQ-014 SHALL have port multi_err  output  1  one-cycle pulse: more than one row active in a sample.
REQ-015 SHALL have port overflow  output  1  one-cycle pulse: qualified key dropped.

Function
REQ-016 SHALL pass read_row through a 2-flop synchronizer; all decisions use the synchronized value only.
REQ-017 SHALL run a dwell counter 0..SCAN_DIV-1 per column; a "sample" is the synchronized rows at count SCAN_DIV-1.
REQ-018 SHALL implement states IDLE, SCAN, DEBOUNCE, HELD.
REQ-019 IDLE: scan_col all ones, counters zero; enable=1 -> SCAN next cycle with column 0 driven and dwell count 0.
REQ-020 SCAN: sample zero rows -> advance column (COLS-1 wraps to 0); exactly one row -> DEBOUNCE with column held, match count 1; more than one row -> multi_err pulse, advance column.
REQ-021 DEBOUNCE: sample equal to captured row -> count+1; count reaching DEBOUNCE -> emit key, enter HELD; any other sample -> SCAN, advance column, no event; DEBOUNCE=1 emits on the first sample.
REQ-022 HELD: column held; DEBOUNCE consecutive zero samples -> SCAN, advance column; non-zero sample resets release count; no repeat events.
REQ-023 Emit: load key_row/key_col with indices, assert key_valid next cycle.
REQ-024 key_valid SHALL stay high, and key_row/key_col stable, until a cycle with key_ready=1; then deassert next cycle.
REQ-025 Emit while key_valid=1 and key_ready=0 -> new key dropped, old retained, overflow pulse.
REQ-026 Emit in same cycle as accept -> new key loaded, key_valid stays high, no overflow.
REQ-027 enable=0 in any state -> IDLE next cycle, scan_col all ones, scan/debounce progress discarded; pending key_valid and its data retained.
REQ-028 Advancing column SHALL reset dwell count to 0; scan_col SHALL change only at dwell boundaries or on IDLE entry.

Reset
REQ-029 On nRst=0: state IDLE, scan_col all ones, key_valid 0, key_row 0, key_col 0, multi_err 0, overflow 0, synchronizer and counters 0.
REQ-030 Press held during reset release SHALL produce no event until qualified by REQ-020..021.

Verification (ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=2)
REQ-031 Row 2 active whenever scan_col=4'b1101, key_ready=1 -> one key_valid pulse, key_row=2, key_col=1; scan_col holds 4'b1101 until release qualified.
REQ-032 Rows 0 and 3 active on column 0 -> multi_err pulse at each sample on column 0, no key_valid, column keeps advancing.
REQ-033 key_ready=0, press (1,0), release, press (3,3) -> key_valid holds row1/col0, overflow pulse on second emit, data unchanged.
REQ-034 Single-sample glitch on row 1 during DEBOUNCE -> no event, return to SCAN, column advances.
REQ-035 enable dropped during DEBOUNCE -> scan_col=4'b1111 next cycle; re-enable restarts at column 0 (4'b1110).
REQ-036 nRst asserted mid-HELD with key_valid=1 -> all outputs at REQ-029 values asynchronously.
